// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: constants and types shared by the pipeline controller.
//   - stall vector encodings (bit0 PC .. bit4 MEM/WB, bit5 reserved = 0)
//   - controller FSM state encodings
//   - common word / reset-level constants
//   - stall_select: fixed-priority MEM > EX > ID stall vector chooser
package pipe_ctrl_pkg;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b1;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallMem  = 6'b011111;

    typedef enum logic {
        CtrlRun       = 1'b0,
        CtrlFlushHold = 1'b1
    } ctrl_state_t;

    // A stall request freezes the requesting stage and everything upstream
    // of it, so the deepest requester decides the vector.
    function automatic logic [5:0] stall_select(input logic req_id,
                                                input logic req_ex,
                                                input logic req_mem);
        logic [5:0] v;
        if (req_mem)     v = StallMem;
        else if (req_ex) v = StallEx;
        else if (req_id) v = StallId;
        else             v = StallNone;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   - clock
//   rst   - synchronous active-high reset, clears count
//   inc   - count up by one this cycle (ignored when saturated)
//   clr   - synchronous clear, takes priority over inc
//   count - current value
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline controller for the five-stage MIPS32 core.
//   clk, rst       - clock, synchronous active-high reset
//   stallreq_id    - ID load-use bubble request
//   stallreq_ex    - EX multi-cycle op busy
//   stallreq_mem   - MEM waiting on data bus
//   excp_req       - MEM-stage exception or ERET
//   excp_is_eret   - qualifies excp_req as ERET
//   excp_vec       - exception handler address
//   cp0_epc        - ERET return address
//   stall[5:0]     - per-stage stall vector (combinational)
//   flush          - clear all pipeline registers (combinational)
//   new_pc         - redirect target; live mux in the flush cycle, held otherwise
//   stall_cycles   - saturating count of stalled cycles
//   wdog_trip      - sticky: stall held WDOG_LIMIT consecutive cycles
//   state_dbg      - controller FSM state (0 RUN, 1 FLUSH_HOLD)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_req,
    input  logic             excp_is_eret,
    input  logic [31:0]      excp_vec,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             wdog_trip,
    output logic             state_dbg
);

    localparam int RUN_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [RUN_W-1:0] RunLimit   = RUN_W'(WDOG_LIMIT);
    localparam logic [RUN_W-1:0] RunLimitM1 = RUN_W'(WDOG_LIMIT - 1);

    ctrl_state_t      state;
    logic [31:0]      new_pc_q;
    logic [RUN_W-1:0] run_cnt;
    logic             stall_active;
    logic             run_inc;
    logic             run_clr;

    // In FLUSH_HOLD the MEM stage still holds the faulting instruction, so
    // its excp_req is stale and must not trigger a second flush.
    always_comb begin
        stall  = StallNone;
        flush  = 1'b0;
        new_pc = new_pc_q;
        if (rst != RstEnable) begin
            if ((state == CtrlRun) && excp_req) begin
                flush  = 1'b1;
                new_pc = excp_is_eret ? cp0_epc : excp_vec;
            end else begin
                stall = stall_select(stallreq_id, stallreq_ex, stallreq_mem);
            end
        end
    end

    assign stall_active = (stall != StallNone);
    assign run_inc      = stall_active && (run_cnt != RunLimit);
    assign run_clr      = !stall_active || flush;
    assign state_dbg    = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_active),
        .clr   (1'b0),
        .count (stall_cycles)
    );

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (run_inc),
        .clr   (run_clr),
        .count (run_cnt)
    );

    // Trip on the same edge the run counter reaches the limit, so a stall
    // of exactly WDOG_LIMIT cycles is visible right after its last cycle.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state     <= CtrlRun;
            new_pc_q  <= ZeroWord;
            wdog_trip <= 1'b0;
        end else begin
            state <= flush ? CtrlFlushHold : CtrlRun;
            if (flush) begin
                new_pc_q <= new_pc;
            end
            if (stall_active && (run_cnt >= RunLimitM1)) begin
                wdog_trip <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int WDOG = 8;
  localparam int CW   = 4;
  localparam int CNT_MAX = 15;

  logic          clk;
  logic          rst;
  logic          stallreq_id;
  logic          stallreq_ex;
  logic          stallreq_mem;
  logic          excp_req;
  logic          excp_is_eret;
  logic [31:0]   excp_vec;
  logic [31:0]   cp0_epc;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic [CW-1:0] stall_cycles;
  logic          wdog_trip;
  logic          state_dbg;

  pipe_ctrl #(.WDOG_LIMIT(WDOG), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_req     (excp_req),
    .excp_is_eret (excp_is_eret),
    .excp_vec     (excp_vec),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_cycles (stall_cycles),
    .wdog_trip    (wdog_trip),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {stall, flush, new_pc, stall_cycles, wdog_trip, state}
  localparam int EW = 6 + 1 + 32 + CW + 1 + 1;
  logic [EW-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_newpc = 32'h0;
  int          m_cnt = 0;
  int          m_run = 0;
  logic        m_trip = 1'b0;
  logic        m_state = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, predict outputs, compare at negedge, then
  // advance the model across the posedge.
  task automatic run_cycle(input logic r, input logic id, input logic ex, input logic mem,
                           input logic xr, input logic er,
                           input logic [31:0] vec, input logic [31:0] epc);
    logic [5:0]    e_st;
    logic          e_fl;
    logic [31:0]   e_pc;
    logic [EW-1:0] e;
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excp_req = xr; excp_is_eret = er; excp_vec = vec; cp0_epc = epc;

    e_st = 6'b000000; e_fl = 1'b0; e_pc = m_newpc;
    if (!r) begin
      if (!m_state && xr) begin
        e_fl = 1'b1;
        e_pc = er ? epc : vec;
      end else if (mem) e_st = 6'b011111;
      else if (ex)      e_st = 6'b001111;
      else if (id)      e_st = 6'b000111;
    end
    exp_q.push_back({e_st, e_fl, e_pc, CW'(m_cnt), m_trip, m_state});

    @(negedge clk);
    e = exp_q.pop_front();
    check("stall",        32'(stall),        32'(e[EW-1 -: 6]));
    check("flush",        32'(flush),        32'(e[EW-7]));
    check("new_pc",       new_pc,            e[EW-8 -: 32]);
    check("stall_cycles", 32'(stall_cycles), 32'(e[CW+1 : 2]));
    check("wdog_trip",    32'(wdog_trip),    32'(e[1]));
    check("state",        32'(state_dbg),    32'(e[0]));

    @(posedge clk);
    if (r) begin
      m_newpc = 32'h0; m_cnt = 0; m_run = 0; m_trip = 1'b0; m_state = 1'b0;
    end else begin
      if (e_fl) m_newpc = e_pc;
      m_state = e_fl;
      if (e_st != 6'b0) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_run < WDOG) m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run == WDOG) m_trip = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b1; stallreq_ex = 1'b1; stallreq_mem = 1'b1;
    excp_req = 1'b1; excp_is_eret = 1'b0; excp_vec = 32'h0; cp0_epc = 32'h0;
    @(posedge clk); #1;

    // reset with every request asserted
    run_cycle(1, 1, 1, 1, 1, 0, 32'h0, 32'h0);
    run_cycle(1, 1, 1, 1, 1, 0, 32'h0, 32'h0);
    check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    check("rst_wdog", 32'(wdog_trip), 32'd0);

    // stall priority ID -> +EX -> +MEM
    run_cycle(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    run_cycle(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    run_cycle(0, 1, 1, 1, 0, 0, 32'h0, 32'h0);
    check("prio_stall_cycles", 32'(stall_cycles), 32'd3);
    idle(1);

    // exception with a competing MEM stall; excp_req lingers into the hold cycle
    run_cycle(0, 0, 0, 1, 1, 0, 32'h0000_0020, 32'h0);
    check("excp_hold_flush", 32'(flush), 32'd0);
    check("excp_hold_pc", new_pc, 32'h0000_0020);
    run_cycle(0, 0, 0, 1, 1, 0, 32'h0000_0020, 32'h0);
    idle(1);

    // ERET
    run_cycle(0, 0, 0, 0, 1, 1, 32'h0000_0020, 32'h0040_0104);
    idle(2);
    check("eret_pc_held", new_pc, 32'h0040_0104);

    // back-to-back: second dropped, third accepted
    run_cycle(0, 0, 0, 0, 1, 0, 32'h0000_0180, 32'h0);
    run_cycle(0, 0, 0, 0, 1, 0, 32'h0000_0200, 32'h0);
    run_cycle(0, 0, 0, 0, 1, 1, 32'h0000_0280, 32'h0000_1234);
    idle(1);
    check("b2b_pc", new_pc, 32'h0000_1234);

    // reset while in FLUSH_HOLD
    run_cycle(0, 0, 1, 0, 1, 0, 32'h0000_0300, 32'h0);
    run_cycle(1, 1, 1, 1, 1, 0, 32'h0000_0300, 32'h0);
    check("rst_mid_state", 32'(state_dbg), 32'd0);
    check("rst_mid_cnt", 32'(stall_cycles), 32'd0);
    run_cycle(0, 0, 0, 0, 1, 0, 32'h0000_0380, 32'h0);
    idle(1);

    // watchdog: 7 stalled, 1 clear, 8 stalled
    for (int i = 0; i < WDOG - 1; i++) run_cycle(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    check("wdog_below", 32'(wdog_trip), 32'd0);
    idle(1);
    for (int i = 0; i < WDOG; i++) run_cycle(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    check("wdog_at_limit", 32'(wdog_trip), 32'd1);
    idle(3);
    check("wdog_sticky", 32'(wdog_trip), 32'd1);

    // counter saturation
    run_cycle(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++)
      run_cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 0, 32'h0, 32'h0);
    check("sat_count", 32'(stall_cycles), 32'd15);

    // random mix
    run_cycle(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 80; i++)
      run_cycle(1'($urandom_range(0, 30) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 1)), $urandom, $urandom);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the five-stage MIPS32 core. It collects stall requests from ID, EX and MEM, and produces the per-stage stall vector that every pipeline register, including MEM/WB, obeys. It sequences exception/ERET flushes and redirects the PC. It also keeps a stall-cycle performance counter and a stuck-pipeline watchdog.

## Interface
Parameters:
- WDOG_LIMIT, default 1024: consecutive stalled cycles that trip the watchdog.
- CNT_W, default 32: width of the stall-cycle counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- stallreq_id, input, 1: ID needs a bubble (load-use hazard).
- stallreq_ex, input, 1: EX busy with a multi-cycle op (mult/div).
- stallreq_mem, input, 1: MEM waiting on the data bus.
- excp_req, input, 1: MEM-stage instruction raised an exception or is ERET.
- excp_is_eret, input, 1: qualifies excp_req as ERET.
- excp_vec, input, 32: exception handler address.
- cp0_epc, input, 32: return address for ERET.
- stall, output, 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved and always 0.
- flush, output, 1: clear all pipeline registers this cycle.
- new_pc, output, 32: PC redirect target, valid when flush=1.
- stall_cycles, output, CNT_W: saturating count of cycles with stall≠0.
- wdog_trip, output, 1: sticky; stall held ≥ WDOG_LIMIT consecutive cycles.

## Operation
- FSM states: RUN, FLUSH_HOLD. Reset state is RUN.
- **RUN, excp_req=1**
  - Combinationally: flush=1, stall=0.
  - new_pc = cp0_epc if excp_is_eret, else excp_vec.
  - Next state is FLUSH_HOLD.
- **FLUSH_HOLD**
  - Lasts exactly one cycle.
  - flush=0. excp_req is ignored, because it comes from the residual MEM contents.
  - Stall requests are honoured normally.
  - Returns to RUN.
- **No flush:** stall is chosen by fixed priority, MEM > EX > ID.
  - stallreq_mem gives 6'b011111.
  - else stallreq_ex gives 6'b001111.
  - else stallreq_id gives 6'b000111.
  - else 6'b000000.
- **Flush wins over any stall request:** when excp_req and stallreq_* are both high in RUN, the output is flush=1, stall=0.
- **new_pc hold:** new_pc is registered and holds its last target. It drives the excp_vec/cp0_epc mux combinationally only in the flush cycle.
- **stall_cycles:** increments on each cycle with stall≠0 and saturates at all-ones.
- **Watchdog:**
  - An internal run counter increments while stall≠0 and clears when stall=0 or flush=1.
  - When the run counter reaches WDOG_LIMIT, wdog_trip is set.
  - wdog_trip clears only on rst.
  - The run counter saturates at WDOG_LIMIT.

## Timing
- **Reset values:** stall=0, flush=0, new_pc=0, stall_cycles=0, wdog_trip=0, state=RUN, run counter=0.
- **rst has priority:** while rst=1, stall and flush are forced to 0 regardless of inputs.
- **Zero-latency outputs:** stall, flush and new_pc (during the flush cycle) are combinational from the current-cycle inputs and state.
- **Registered outputs:** counters, wdog_trip, state and the held new_pc update on the clk edge.
- **stall_cycles latency:** the count reflects a stalled cycle on the following edge, so it has one-cycle latency.
- **Back-to-back exceptions:** an excp_req arriving in the FLUSH_HOLD cycle is dropped. An excp_req two cycles after a flush is accepted.
- **Reset mid-FLUSH_HOLD:** the FSM returns to RUN and the counters clear on that edge.
- **Watchdog boundary:** a stall lasting exactly WDOG_LIMIT cycles trips the watchdog. WDOG_LIMIT−1 cycles does not.

## Structure
- Shared define file additions:
  - stall vector constants: StallNone, StallId, StallEx, StallMem.
  - FSM state encodings: CtrlRun, CtrlFlushHold.
  - Existing constants reused: ZeroWord, RstEnable.
- Sub-module sat_counter (parameter W; inputs clk, rst, inc, clr; output count). Instantiate it twice:
  - stall_cycles: clr tied 0.
  - watchdog run counter: W = clog2(WDOG_LIMIT+1), with clr driven.

## Test plan
- **Reset:** assert rst for 2 cycles with all stallreq_*=1 and excp_req=1.
  - Expect stall=0, flush=0, new_pc=0, stall_cycles=0, wdog_trip=0.
- **Stall priority:** stallreq_id=1 alone, then add stallreq_ex, then add stallreq_mem.
  - Expect stall 000111, then 001111, then 011111.
  - stall_cycles=3 after the third edge.
- **Exception:** excp_req=1, excp_vec=0x00000020, stallreq_mem=1.
  - Expect flush=1, stall=0, new_pc=0x20 in the same cycle.
  - Next cycle: flush=0 while excp_req is still 1.
- **ERET:** excp_req=1, excp_is_eret=1, cp0_epc=0x00400104.
  - Expect new_pc=0x00400104 with flush=1.
  - new_pc holds 0x00400104 afterwards.
- **Watchdog:** WDOG_LIMIT=8.
  - stallreq_ex high for 7 cycles, low for 1, then high for 8 cycles.
  - Expect wdog_trip low after the first burst and high after the 8th cycle of the second burst.
  - wdog_trip stays high after stalls clear.
- **Saturation:** CNT_W=4 with a continuous stall for 20 cycles.
  - Expect stall_cycles=15 with no wrap.
